// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the unified memory.
// slave = arbiter view; master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
  parameter int N = 32
);
  logic         if_req;
  logic [N-1:0] if_addr;
  logic [N-1:0] if_rdata;
  logic         if_ack;
  logic         d_req;
  logic         d_we;
  logic [N-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic [2:0]   d_size;
  logic [N-1:0] d_rdata;
  logic         d_ack;
  logic         mem_en;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [2:0]   mem_size;
  logic [N-1:0] mem_rdata;
  logic         mem_ready;
  logic         stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, mem_size, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, mem_size, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and load/store.
// Data has priority; a streak counter forces a fetch grant after STARVE_LIM data grants.
module mem_port_arbiter #(
  parameter int N          = 32,
  parameter int STARVE_LIM = 4
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_D,
    RESP_IF,
    RESP_D
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;

  assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      streak        <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_size  <= '0;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          // A pending fetch wins only once data has taken STARVE_LIM grants in a row.
          if (bus.d_req && !(bus.if_req && streak == LIM)) begin
            state         <= BUSY_D;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_size  <= bus.d_size;
            if (!bus.if_req)
              streak <= '0;
            else if (streak != LIM)
              streak <= streak + 1'b1;
          end else if (bus.if_req) begin
            state         <= BUSY_IF;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            bus.mem_size  <= 3'b010;
            streak        <= '0;
          end
        end
        BUSY_IF: begin
          if (bus.mem_ready) begin
            state        <= RESP_IF;
            bus.mem_en   <= 1'b0;
            bus.if_rdata <= bus.mem_rdata;
            bus.if_ack   <= 1'b1;
          end
        end
        BUSY_D: begin
          if (bus.mem_ready) begin
            state      <= RESP_D;
            bus.mem_en <= 1'b0;
            bus.d_ack  <= 1'b1;
            if (!bus.mem_we)
              bus.d_rdata <= bus.mem_rdata;
          end
        end
        RESP_IF, RESP_D: state <= IDLE;
        default:         state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (N=32, STARVE_LIM=4).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.N(32)) bus ();

  mem_port_arbiter #(.N(32), .STARVE_LIM(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] is_fetch;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;

    // Reset state
    #3;
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_size", 32'(bus.mem_size), 0);
    chk("rst_acks", {30'd0, bus.if_ack, bus.d_ack}, 0);
    chk("rst_rdata", bus.if_rdata | bus.d_rdata, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    tick();
    chk("idle_mem_en", 32'(bus.mem_en), 0);

    // Lone fetch, zero-wait
    bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_ready = 1; bus.mem_rdata = 32'h00500093;
    tick();
    chk("f_mem_en", 32'(bus.mem_en), 1);
    chk("f_mem_we", 32'(bus.mem_we), 0);
    chk("f_mem_size", 32'(bus.mem_size), 32'h2);
    chk("f_mem_addr", bus.mem_addr, 32'h100);
    chk("f_mem_wdata", bus.mem_wdata, 0);
    chk("f_stall_busy", 32'(bus.stall), 1);
    tick();
    chk("f_if_ack", 32'(bus.if_ack), 1);
    chk("f_if_rdata", bus.if_rdata, 32'h00500093);
    chk("f_mem_en_resp", 32'(bus.mem_en), 0);
    chk("f_stall_ack", 32'(bus.stall), 0);
    bus.if_req = 0; bus.mem_ready = 0;
    tick();
    chk("f_ack_pulse", 32'(bus.if_ack), 0);

    // Store with 3 wait cycles
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF; bus.d_size = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin bus.mem_ready = 1; bus.mem_rdata = 32'h12345678; end
      chk("st_mem_en", 32'(bus.mem_en), 1);
      chk("st_mem_addr", bus.mem_addr, 32'h2000);
      chk("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      chk("st_mem_we", 32'(bus.mem_we), 1);
      chk("st_d_ack_wait", 32'(bus.d_ack), 0);
    end
    tick();
    chk("st_d_ack", 32'(bus.d_ack), 1);
    chk("st_d_rdata_kept", bus.d_rdata, 0);
    bus.d_req = 0; bus.mem_ready = 0;
    tick();
    chk("st_ack_pulse", 32'(bus.d_ack), 0);

    // Simultaneous fetch and load: data first, then fetch
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000; bus.d_size = 3'b100;
    bus.mem_ready = 1; bus.mem_rdata = 32'hAAAA0001;
    tick();
    chk("both_d_addr", bus.mem_addr, 32'h3000);
    chk("both_d_size", 32'(bus.mem_size), 32'h4);
    tick();
    chk("both_d_ack", 32'(bus.d_ack), 1);
    chk("both_d_rdata", bus.d_rdata, 32'hAAAA0001);
    chk("both_if_ack_no", 32'(bus.if_ack), 0);
    chk("both_stall", 32'(bus.stall), 1);
    bus.d_req = 0;
    tick();
    chk("both_idle", 32'(bus.mem_en), 0);
    bus.mem_rdata = 32'h00000013;
    tick();
    chk("both_f_addr", bus.mem_addr, 32'h104);
    chk("both_f_size", 32'(bus.mem_size), 32'h2);
    tick();
    chk("both_if_ack", 32'(bus.if_ack), 1);
    chk("both_if_rdata", bus.if_rdata, 32'h00000013);
    bus.if_req = 0;
    tick();

    // Starvation guard: D D D D I D with both requests held
    is_fetch = 4'b0000;
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h4000; bus.d_size = 3'b010;
    bus.mem_ready = 1; bus.mem_rdata = 32'h55;
    for (int g = 0; g < 6; g++) begin
      is_fetch[0] = (g == 4);
      tick();
      chk($sformatf("sv_g%0d_addr", g), bus.mem_addr, is_fetch[0] ? 32'h200 : 32'h4000);
      tick();
      chk($sformatf("sv_g%0d_if_ack", g), 32'(bus.if_ack), is_fetch[0] ? 1 : 0);
      chk($sformatf("sv_g%0d_d_ack", g), 32'(bus.d_ack), is_fetch[0] ? 0 : 1);
      tick();
    end
    bus.if_req = 0; bus.d_req = 0; bus.mem_ready = 0;
    tick();
    chk("sv_idle", 32'(bus.mem_en), 0);

    // Load dropped during BUSY_D, then spurious mem_ready in IDLE
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h5000;
    tick();
    bus.d_req = 0; bus.d_addr = 32'h6000;
    chk("drop_addr", bus.mem_addr, 32'h5000);
    tick();
    chk("drop_addr_held", bus.mem_addr, 32'h5000);
    chk("drop_stall", 32'(bus.stall), 0);
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFEF00D;
    tick();
    chk("drop_d_ack", 32'(bus.d_ack), 1);
    chk("drop_d_rdata", bus.d_rdata, 32'hCAFEF00D);
    bus.mem_rdata = 32'h11111111;
    tick();
    chk("drop_ack_pulse", 32'(bus.d_ack), 0);
    tick();
    chk("spur_acks", {30'd0, bus.if_ack, bus.d_ack}, 0);
    chk("spur_mem_en", 32'(bus.mem_en), 0);
    chk("spur_d_rdata", bus.d_rdata, 32'hCAFEF00D);
    bus.mem_ready = 0;

    // Asynchronous reset mid BUSY_D, then held fetch granted after release
    bus.if_req = 1; bus.if_addr = 32'h300;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h7000; bus.d_wdata = 32'h77;
    tick();
    chk("ar_busy_addr", bus.mem_addr, 32'h7000);
    #2 rst_n = 0;
    #1;
    chk("ar_mem_en", 32'(bus.mem_en), 0);
    chk("ar_acks", {30'd0, bus.if_ack, bus.d_ack}, 0);
    chk("ar_rdata", bus.if_rdata | bus.d_rdata, 0);
    chk("ar_mem_addr", bus.mem_addr, 0);
    bus.d_req = 0;
    tick();
    rst_n = 1;
    tick();
    chk("ar_f_en", 32'(bus.mem_en), 1);
    chk("ar_f_addr", bus.mem_addr, 32'h300);
    bus.mem_ready = 1; bus.mem_rdata = 32'h00100073;
    tick();
    chk("ar_f_ack", 32'(bus.if_ack), 1);
    chk("ar_f_rdata", bus.if_rdata, 32'h00100073);
    bus.if_req = 0; bus.mem_ready = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data memory between the fetch stage (instruction reads) and the load/store path (MemRead/MemWrite accesses from the control unit). Grants one requester at a time, holds the memory command stable until the memory signals completion, returns read data with a one-cycle acknowledge, and raises a stall to the pipeline while any request is outstanding. Data accesses have priority; a streak counter guarantees fetch progress.

## Interface
- N, 32, data and address width
- STARVE_LIM, 4, max consecutive data grants while a fetch is pending before fetch is forced (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high with if_addr stable until if_ack
- if_addr  in  N  fetch address
- if_rdata  out  N  fetched instruction; valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request (MemRead|MemWrite); held with d_* stable until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  N  data address
- d_wdata  in  N  store data
- d_size  in  3  funct3 access size/sign, passed through
- d_rdata  out  N  load data; valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory command valid
- mem_we  out  1  memory write enable
- mem_addr  out  N  memory address
- mem_wdata  out  N  memory write data
- mem_size  out  3  access size (000 for fetch is overridden to 010, word)
- mem_rdata  in  N  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the current command this cycle
- stall  out  1  pipeline stall

## Operation
- States: IDLE, BUSY_IF, BUSY_D, RESP_IF, RESP_D.
- IDLE: if d_req and not (if_req and streak==STARVE_LIM) -> BUSY_D; else if if_req -> BUSY_IF; else stay.
- On grant, register address/wdata/we/size into mem_* outputs; fetch grant drives mem_we=0, mem_size=010, mem_wdata=0.
- BUSY_x: mem_en=1, mem_* held constant; on mem_ready capture mem_rdata into x_rdata (stores capture nothing, d_rdata keeps old value) -> RESP_x; else stay (unbounded wait).
- RESP_x: x_ack=1 for exactly one cycle, mem_en=0; -> IDLE. Requests are not sampled in RESP.
- streak (width clog2(STARVE_LIM+1)): on data grant with if_req=1, increment (saturate at STARVE_LIM); on data grant with if_req=0 or on any fetch grant, clear to 0.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
- Requester drops/changes req during BUSY: access completes with latched command and ack is still pulsed.
- mem_ready outside BUSY states: ignored.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_size=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, streak=0.
- Zero-wait memory (mem_ready high in first BUSY cycle): req seen in IDLE cycle t, mem_en high cycle t+1, ack cycle t+2, next grant possible cycle t+3 → 3 cycles/access.
- k wait cycles add k cycles to latency.
- mem_* outputs are registers; change only on IDLE->BUSY transition.
- Simultaneous if_req and d_req in IDLE: data wins unless streak==STARVE_LIM, then fetch wins and streak clears.

## Test plan
- Reset mid-BUSY_D with mem_ready low: rst_n=0 -> mem_en=0, acks 0, rdata 0 immediately; after release a held if_req is granted 1 cycle later.
- Lone fetch, zero-wait, if_addr=0x100, mem_rdata=0x00500093 -> mem_en cycle 1, mem_we=0, mem_size=010, if_ack with if_rdata=0x00500093 cycle 2, stall low cycle 2.
- Store with 3 wait cycles, d_addr=0x2000, d_wdata=0xDEADBEEF, d_size=010 -> mem_* stable 4 cycles, d_ack one cycle after mem_ready, d_rdata unchanged.
- if_req and d_req together, both held: data granted first; fetch acked next.
- if_req held, d_req reasserted back-to-back, STARVE_LIM=4 -> exactly 4 data grants, then fetch grant, then streak=0 and data resumes.
- Load d_req dropped during BUSY_D -> access completes, d_ack pulses once; spurious mem_ready in IDLE -> no ack, no state change.
